// File: rtl/dac_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dac_pkg
// Purpose  : Shared types and helpers for the slew-limited PWL DAC.
//            Voltages are signed integers in millivolts; time is an unsigned
//            count of clock ticks, one tick being the time resolution TU.
//            A PWL segment is the triple (a, b, t0): value a at tick t0,
//            slope b in mV per tick.
// Contents : state enum, ramp record, code-to-clipped-target function.
// Revision : 1.0  initial release
// ============================================================================
package dac_pkg;

    localparam int C_VW = 16;   // voltage word width (signed mV)
    localparam int C_TW = 32;   // time word width (ticks)
    localparam int C_GW = 8;    // generation counter width

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RAMP = 1'b1
    } state_e;

    // Pending ramp: target, start tick, duration and the generation tag
    // that must still be current when the end event fires.
    typedef struct packed {
        logic signed [C_VW-1:0] vt;
        logic [C_TW-1:0]        t_start;
        logic [C_TW-1:0]        dt;
        logic [C_GW-1:0]        gen;
    } ramp_t;

    typedef struct packed {
        logic signed [C_VW-1:0] v;
        logic                   sat;
    } target_t;

    // vt = vofs + code*lsb, clipped to [vmin, vmax]; sat flags the clip.
    function automatic target_t code_to_target(
        input logic signed [31:0] code,
        input int                 lsb,
        input int                 vofs,
        input int                 vmin,
        input int                 vmax
    );
        target_t r;
        int      v;
        v     = vofs + code * lsb;
        r.sat = 1'b0;
        if (v > vmax) begin
            v     = vmax;
            r.sat = 1'b1;
        end else if (v < vmin) begin
            v     = vmin;
            r.sat = 1'b1;
        end
        r.v = C_VW'(v);
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pwl_ramp_seg.sv
`default_nettype none
// ============================================================================
// Module   : pwl_ramp_seg
// Purpose  : Owns the PWL output segment. On a start strobe it evaluates the
//            current output, then either steps straight to the target (small
//            delta) or launches a ramp of slope +/-SR_STEP and schedules its
//            end. It owns the generation counter and writes the exact target
//            when the end event of the current generation fires.
// Ports    : clk, rstb      clock, async active-low reset
//            start_i        accept strobe (new target this edge)
//            vt_i           clipped target (mV)
//            now_i          current tick
//            out_a_o/b_o/t_o PWL segment (value mV, slope mV/tick, start tick)
//            busy_o         ramp in progress
// Revision : 1.0  initial release
// ============================================================================
module pwl_ramp_seg
    import dac_pkg::*;
#(
    parameter int VOFS_MV = 0,
    parameter int SR_STEP = 1,
    parameter int ETOL_MV = 1
) (
    input  logic                   clk,
    input  logic                   rstb,
    input  logic                   start_i,
    input  logic signed [C_VW-1:0] vt_i,
    input  logic [C_TW-1:0]        now_i,
    output logic signed [C_VW-1:0] out_a_o,
    output logic signed [C_VW-1:0] out_b_o,
    output logic [C_TW-1:0]        out_t_o,
    output logic                   busy_o
);

    localparam logic signed [C_VW-1:0] C_SR = C_VW'(SR_STEP);

    state_e                 state_q, state_d;
    ramp_t                  ramp_q,  ramp_d;
    logic [C_GW-1:0]        gen_q,   gen_d;
    logic signed [C_VW-1:0] a_q,     a_d;
    logic signed [C_VW-1:0] b_q,     b_d;
    logic [C_TW-1:0]        t_q,     t_d;

    logic [C_TW-1:0]  elapsed_w;
    logic signed [31:0] vc_w;
    logic signed [31:0] diff_w;
    logic signed [31:0] absd_w;
    logic signed [31:0] dt_raw_w;
    logic [C_TW-1:0]  dt_w;
    logic             end_hit_w;

    // Evaluate the live segment at the current tick; this is the start value
    // of a retargeted ramp, so the output stays continuous.
    assign elapsed_w = now_i - t_q;
    assign vc_w      = 32'(a_q) + 32'(b_q) * $signed(elapsed_w);
    assign diff_w    = 32'(vt_i) - vc_w;
    assign absd_w    = diff_w[31] ? -diff_w : diff_w;
    // Round up so the ramp never ends short; the end write removes overshoot.
    assign dt_raw_w  = (absd_w + 32'(SR_STEP) - 32'sd1) / 32'(SR_STEP);
    assign dt_w      = (dt_raw_w < 32'sd1) ? C_TW'(1) : C_TW'(dt_raw_w);

    assign end_hit_w = (state_q == RAMP) && (ramp_q.gen == gen_q)
                       && (now_i == ramp_q.t_start + ramp_q.dt);

    always_comb begin
        state_d = state_q;
        ramp_d  = ramp_q;
        gen_d   = gen_q;
        a_d     = a_q;
        b_d     = b_q;
        t_d     = t_q;
        if (start_i) begin
            // An accept always wins over a coincident end event: the new
            // generation makes the pending end stale.
            gen_d = gen_q + C_GW'(1);
            t_d   = now_i;
            if (absd_w < ETOL_MV) begin
                a_d     = vt_i;
                b_d     = '0;
                state_d = IDLE;
            end else begin
                a_d            = C_VW'(vc_w);
                b_d            = diff_w[31] ? -C_SR : C_SR;
                state_d        = RAMP;
                ramp_d.vt      = vt_i;
                ramp_d.t_start = now_i;
                ramp_d.dt      = dt_w;
                ramp_d.gen     = gen_d;
            end
        end else if (end_hit_w) begin
            a_d     = ramp_q.vt;
            b_d     = '0;
            t_d     = now_i;
            state_d = IDLE;
        end
    end

    // Reset discards any pending ramp record, which cancels its end event.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q <= IDLE;
            ramp_q  <= '0;
            gen_q   <= '0;
            a_q     <= C_VW'(VOFS_MV);
            b_q     <= '0;
            t_q     <= '0;
        end else begin
            state_q <= state_d;
            ramp_q  <= ramp_d;
            gen_q   <= gen_d;
            a_q     <= a_d;
            b_q     <= b_d;
            t_q     <= t_d;
        end
    end

    assign out_a_o = a_q;
    assign out_b_o = b_q;
    assign out_t_o = t_q;
    assign busy_o  = (state_q == RAMP);

endmodule
`default_nettype wire

// File: rtl/pwl_dac_slew.sv
`default_nettype none
// ============================================================================
// Module   : pwl_dac_slew
// Purpose  : Slew-limited DAC producing a PWL segment stream. Accepts a signed
//            code on each qualified clock edge, maps it to a clipped target
//            voltage and hands it to the ramp engine.
// Ports    : clk, rstb       clock, async active-low reset
//            din_i           signed code (NBIT)
//            din_valid_i     qualifies din_i
//            out_a_o/b_o/t_o PWL output (value mV, slope mV/tick, start tick)
//            busy_o          ramp in progress
//            sat_o           last accepted target was clipped
// Revision : 1.0  initial release
// ============================================================================
module pwl_dac_slew
    import dac_pkg::*;
#(
    parameter int NBIT    = 8,
    parameter int LSB_MV  = 10,
    parameter int VOFS_MV = 0,
    parameter int VMIN_MV = -1000,
    parameter int VMAX_MV = 1000,
    parameter int SR_STEP = 1,
    parameter int ETOL_MV = 1
) (
    input  logic                   clk,
    input  logic                   rstb,
    input  logic signed [NBIT-1:0] din_i,
    input  logic                   din_valid_i,
    output logic signed [C_VW-1:0] out_a_o,
    output logic signed [C_VW-1:0] out_b_o,
    output logic [C_TW-1:0]        out_t_o,
    output logic                   busy_o,
    output logic                   sat_o
);

    logic [C_TW-1:0] now_q, now_d;
    logic            sat_q, sat_d;
    target_t         tgt_w;

    assign tgt_w = code_to_target(32'(din_i), LSB_MV, VOFS_MV, VMIN_MV, VMAX_MV);

    // Tick counter is the time base of every PWL segment; it restarts at reset.
    always_comb begin
        now_d = now_q + C_TW'(1);
        sat_d = sat_q;
        if (din_valid_i) begin
            sat_d = tgt_w.sat;
        end
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            now_q <= '0;
            sat_q <= 1'b0;
        end else begin
            now_q <= now_d;
            sat_q <= sat_d;
        end
    end

    pwl_ramp_seg #(
        .VOFS_MV (VOFS_MV),
        .SR_STEP (SR_STEP),
        .ETOL_MV (ETOL_MV)
    ) u_ramp (
        .clk     (clk),
        .rstb    (rstb),
        .start_i (din_valid_i),
        .vt_i    (tgt_w.v),
        .now_i   (now_q),
        .out_a_o (out_a_o),
        .out_b_o (out_b_o),
        .out_t_o (out_t_o),
        .busy_o  (busy_o)
    );

    assign sat_o = sat_q;

endmodule
`default_nettype wire

// File: doc/pwl_dac_slew.md
# pwl_dac_slew

Clocked, slew-limited DAC model that converts a digital code stream into a PWL waveform. It is the stage directly upstream of the PWL partial-fraction filter primitive: its `out` is the filter's `in`. Each accepted code becomes a target voltage, reached with a linear ramp of fixed slew rate, so the filter sees finite-slope PWL segments instead of ideal steps. Retargeting mid-ramp, saturation and reset are handled deterministically.

## Interface
- NBIT, 8: code width, two's complement
- LSB, 0.01: volts per code
- VOFS, 0.0: output voltage at code 0 and after reset
- VMIN, -1.0 / VMAX, 1.0: output clamp limits (volts)
- SR, 1e9: slew rate magnitude (V/s), > 0
- etol, 0.001: a target within etol of the current value is applied as an instantaneous step, with no ramp
- clk  input  1  sampling clock; codes accepted on the rising edge
- rstb  input  1  asynchronous, active-low reset
- din  input  NBIT  signed code
- din_valid  input  1  qualifies din on the clk rising edge
- out  output  pwl  DAC output (`output_pwl`), drives the filter input
- busy  output  1  high while a ramp is in progress
- sat  output  1  high when the last accepted target was clipped

## Operation
- States: IDLE (out slope 0, at target) and RAMP (out slope ±SR).
- Accept: on clk rising edge with rstb=1 and din_valid=1, latch din.
- Target: vt = VOFS + signed(din)·LSB, clipped to [VMIN, VMAX].
- sat: set on the accept edge to 1 if vt was clipped, else 0.
- Ramp start:
  - vc = pm.eval(out, now).
  - If |vt−vc| < etol: write out=(vt, 0); stay or return to IDLE; busy=0.
  - Else:
    - dT = ceil(|vt−vc|/SR/TU), minimum 1 timeunit.
    - Write out=(vc, sign(vt−vc)·SR, now); enter RAMP; busy=1.
    - Schedule an end event at now+dT, tagged with the current generation number gen.
- Ramp end: when the end event fires and its tag equals gen, write out=(vt, 0.0, now) exactly; enter IDLE; busy=0.
- Retarget: an accept during RAMP increments gen, which cancels the pending end event. A new ramp starts from the current evaluated value (see Ramp start). This must produce no discontinuity in out.
- din_valid=0 on an edge: no action; the ramp or hold continues.
- Reset (rstb falling edge, asynchronous, at any time):
  - Increment gen.
  - out=(VOFS, 0, now); busy=0; sat=0; state IDLE.
  - While rstb=0, clock edges are ignored.
  - The first edge after rstb rises may accept a code.

## Timing
- Reset values: out.a=VOFS, out.b=0; busy=0; sat=0; state IDLE.
- Accept-to-slope latency: zero. The out write and busy update happen in the same time step as the clk edge.
- Ramp end is not clock aligned. busy falls at accept time + dT, where TU is the resolution.
- Simultaneous end event and accept in the same time step: the accept wins. gen increments, so the stale end event is dropped.
- out is written only at accept, ramp end and reset. No other events are generated, so the filter wakes only on true slope changes.
- Slew accuracy: the out value at ramp end is exactly vt. The slope overshoot from timeunit quantisation is removed at the end write and never exceeds SR·TU.

## Structure
- Shared package `dac_pkg` holds:
  - the state enum (IDLE, RAMP);
  - the ramp record: vt, start time, dT, gen;
  - the function mapping a code to a clipped target (returns value and sat flag).
- Sub-module `pwl_ramp_seg`: given start value, target, SR, etol and a start strobe, it owns the gen counter, end-event scheduling and the final out write. The top level holds the clocked accept logic, the clamp and the reset.
- Use PWLMethod for all out writes and evals; no real-valued output ports.

## Test plan
- Reset: rstb=0 for 3 cycles with random din/din_valid -> out=(0.0, 0), busy=0, sat=0 throughout. After release, code 10 -> ramp to 0.1 V at slope +1e9, busy high for 100 ps.
- Single step: code 0 -> 50, LSB=0.01, SR=1e9 -> slope +1e9 for 500 ps; busy falls at accept+500 ps; out=(0.5, 0) afterwards.
- Retarget: code 100 accepted at t=0, code −20 accepted at t=300 ps -> out continuous at 0.3 V; slope −1e9; ends at −0.2 V at t=800 ps; no end event at t=1 ns.
- Saturation: code 127 with LSB=0.01, VMAX=1.0 -> target 1.0 (not 1.27); sat=1. Next code 10 -> sat=0.
- Small step: code 0 -> 0 (Δ<etol) -> step write with slope 0, busy stays 0. Also test din_valid=0 for 5 cycles mid-ramp -> ramp completes unaffected.
- Reset mid-ramp: rstb falls at t=200 ps of a 500 ps ramp -> out=(VOFS, 0) immediately, busy=0, and the pending end write never occurs.
